// File: rtl/bisect_scheduler_if.sv
// Shared triangle types plus the bus bundle between the bisect scheduler,
// its source, the rasterizer side and the single-triangle bisect datapath.
package defines_package;
  localparam int COORD_W = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } Vertex3D;

  typedef struct packed {
    Vertex3D p;
    Vertex3D q;
    Vertex3D r;
  } Triangle3D;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EVAL    = 3'd1,
    ST_SPLIT_A = 3'd2,
    ST_SPLIT_B = 3'd3,
    ST_EMIT    = 3'd4
  } sched_state_t;
endpackage

// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never waits on ready, and data is held while valid&&!ready.
interface bisect_scheduler_if;
  import defines_package::*;

  logic      in_valid;
  logic      in_ready;
  Triangle3D tri_in;
  logic      out_valid;
  logic      out_ready;
  Triangle3D tri_out;
  Triangle3D bis_tri;
  logic      bis_select;
  Triangle3D bis_result;

  // Scheduler side.
  modport slave (
    input  in_valid, tri_in, out_ready, bis_result,
    output in_ready, out_valid, tri_out, bis_tri, bis_select
  );

  // Environment side: source, rasterizer and bisect datapath.
  modport master (
    output in_valid, tri_in, out_ready, bis_result,
    input  in_ready, out_valid, tri_out, bis_tri, bis_select
  );
endinterface

// File: rtl/bisect_scheduler.sv
// Depth-first recursive bisection of one projected triangle using a LIFO;
// emits every sub-triangle whose x/y manhattan edge lengths fit EDGE_MAX.
module bisect_scheduler
  import defines_package::*;
#(
  parameter int DEPTH    = 8,
  parameter int EDGE_MAX = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  bisect_scheduler_if.slave bus,
  output logic              busy,
  output logic              depth_limit,
  output sched_state_t      dbg_state
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LEN_W = COORD_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(EDGE_MAX);

  sched_state_t     state_q, state_d;
  Triangle3D        stack_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  Triangle3D        bis_tri_q, bis_tri_d;
  Triangle3D        half0_q, half0_d;
  logic             depth_limit_q, depth_limit_d;

  logic             load_src;
  logic             split_wr;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] push_idx;
  Triangle3D        top_tri;
  Triangle3D        rot_tri;
  logic [LEN_W-1:0] l_pq, l_qr, l_rp, max_len;

  function automatic logic [LEN_W-1:0] edge_len(input Vertex3D a, input Vertex3D b);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    dx = (a.x >= b.x) ? (a.x - b.x) : (b.x - a.x);
    dy = (a.y >= b.y) ? (a.y - b.y) : (b.y - a.y);
    return LEN_W'(dx) + LEN_W'(dy);
  endfunction

  assign top_idx  = PTR_W'(count_q - 1'b1);
  assign push_idx = PTR_W'(count_q);
  assign top_tri  = stack_q[top_idx];

  // Longest edge is rotated into PQ; ties prefer PQ, then QR, then RP.
  always_comb begin
    l_pq    = edge_len(top_tri.p, top_tri.q);
    l_qr    = edge_len(top_tri.q, top_tri.r);
    l_rp    = edge_len(top_tri.r, top_tri.p);
    rot_tri = top_tri;
    max_len = l_pq;
    if ((l_pq >= l_qr) && (l_pq >= l_rp)) begin
      rot_tri = top_tri;
      max_len = l_pq;
    end else if (l_qr >= l_rp) begin
      rot_tri.p = top_tri.q;
      rot_tri.q = top_tri.r;
      rot_tri.r = top_tri.p;
      max_len   = l_qr;
    end else begin
      rot_tri.p = top_tri.r;
      rot_tri.q = top_tri.p;
      rot_tri.r = top_tri.q;
      max_len   = l_rp;
    end
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    bis_tri_d     = bis_tri_q;
    half0_d       = half0_q;
    depth_limit_d = depth_limit_q;
    load_src      = 1'b0;
    split_wr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          load_src      = 1'b1;
          count_d       = CNT_W'(1);
          depth_limit_d = 1'b0;
          state_d       = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (count_q == '0) begin
          state_d = ST_IDLE;
        end else if (max_len <= LEN_MAX) begin
          state_d = ST_EMIT;
        end else if (count_q == CNT_FULL) begin
          // No room for the second half: give up on this one and pass it on as-is.
          depth_limit_d = 1'b1;
          state_d       = ST_EMIT;
        end else begin
          bis_tri_d = rot_tri;
          state_d   = ST_SPLIT_A;
        end
      end
      ST_SPLIT_A: begin
        half0_d = bus.bis_result;
        state_d = ST_SPLIT_B;
      end
      ST_SPLIT_B: begin
        split_wr = 1'b1;
        count_d  = count_q + 1'b1;
        state_d  = ST_EVAL;
      end
      ST_EMIT: begin
        if (bus.out_ready) begin
          count_d = count_q - 1'b1;
          state_d = ST_EVAL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      bis_tri_q     <= '0;
      half0_q       <= '0;
      depth_limit_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      bis_tri_q     <= bis_tri_d;
      half0_q       <= half0_d;
      depth_limit_q <= depth_limit_d;
    end
  end

  // Q-side half replaces the top; the P-side half lands above it and is handled first.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      if (load_src) begin
        stack_q[0] <= bus.tri_in;
      end
      if (split_wr) begin
        stack_q[top_idx]  <= bus.bis_result;
        stack_q[push_idx] <= half0_q;
      end
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_EMIT);
  assign bus.tri_out    = (state_q == ST_EMIT) ? top_tri : '0;
  assign bus.bis_tri    = bis_tri_q;
  assign bus.bis_select = (state_q == ST_SPLIT_B);
  assign busy           = (state_q != ST_IDLE);
  assign depth_limit    = depth_limit_q;
  assign dbg_state      = state_q;

endmodule
